// File: rtl/cam_xclk_pkg.sv
// Shared state encoding and default timing constants for the OV7670 power-up sequencer.
package cam_xclk_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWDN_HOLD,
    ST_RST_HOLD,
    ST_SETTLE,
    ST_RDY
  } cam_state_e;

  localparam int DEF_HALF   = 20;
  localparam int PWDN_CYC   = 1000;
  localparam int RST_CYC    = 1000;
  localparam int SETTLE_CYC = 5000;

  function automatic logic is_busy(input cam_state_e s);
    return (s == ST_PWDN_HOLD) || (s == ST_RST_HOLD) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/cam_xclk_seq_div_core.sv
// Programmable even XCLK divider: immediate reload, or a pending reload applied on the
// next high->low toggle so no runt pulse is produced.
module xclk_div_core #(
  parameter int DIV_W    = 6,
  parameter int DEF_HALF = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             apply_now,
  input  logic [DIV_W-1:0] half_in,
  output logic             xclk
);

  logic [DIV_W-1:0] half_reg;
  logic [DIV_W-1:0] pend_reg;
  logic [DIV_W-1:0] count_reg;
  logic             pend_vld_reg;
  logic             xclk_reg;
  logic [DIV_W-1:0] half_clamped;
  logic             wrap;
  logic             run;

  assign half_clamped = (half_in == '0) ? DIV_W'(1) : half_in;
  assign wrap         = (count_reg == half_reg - 1'b1);
  assign run          = !clr && !apply_now;
  assign xclk         = xclk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_reg     <= DIV_W'(DEF_HALF);
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
      count_reg    <= '0;
      xclk_reg     <= 1'b0;
    end else begin
      if (!run || wrap) count_reg <= '0;
      else              count_reg <= count_reg + 1'b1;

      if (clr)              xclk_reg <= 1'b0;
      else if (run && wrap) xclk_reg <= ~xclk_reg;

      // Pending value lands on the falling toggle; a load in the same cycle stays pending.
      if (run && wrap && xclk_reg && pend_vld_reg) begin
        half_reg     <= pend_reg;
        pend_vld_reg <= 1'b0;
      end

      if (apply_now) begin
        half_reg     <= half_clamped;
        pend_vld_reg <= 1'b0;
      end else if (load) begin
        pend_reg     <= half_clamped;
        pend_vld_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_xclk_seq.sv
// OV7670 power-up sequencer and XCLK controller (OFF -> PWDN hold -> reset hold -> settle -> ready).
// Build option XCLK_IDLE_GATE_EN: hold XCLK low and the divider cleared while OFF.
module cam_xclk_seq #(
  parameter int DIV_W      = 6,
  parameter int DEF_HALF   = cam_xclk_pkg::DEF_HALF,
  parameter int PWDN_CYC   = cam_xclk_pkg::PWDN_CYC,
  parameter int RST_CYC    = cam_xclk_pkg::RST_CYC,
  parameter int SETTLE_CYC = cam_xclk_pkg::SETTLE_CYC,
  parameter int CNT_W      = 16
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             DIV_LOAD,
  input  logic [DIV_W-1:0] DIV_HALF_IN,
  output logic             CLK_XCLK,
  output logic             CAM_PWDN,
  output logic             CAM_RST_N,
  output logic             BUSY,
  output logic             READY
);
  import cam_xclk_pkg::*;

  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  cam_state_e       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             pwdn_reg, pwdn_next;
  logic             cam_rst_n_reg, cam_rst_n_next;
  logic             busy_reg, busy_next;
  logic             ready_reg, ready_next;
  logic             div_clr, div_load_pend, div_apply_now;

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg + 1'b1;
    pwdn_next      = 1'b1;
    cam_rst_n_next = 1'b0;
    busy_next      = is_busy(state_reg);
    ready_next     = 1'b0;

    unique case (state_reg)
      ST_OFF:       if (START)                    state_next = ST_PWDN_HOLD;
      ST_PWDN_HOLD: if (timer_reg == PWDN_LAST)   state_next = ST_RST_HOLD;
      ST_RST_HOLD:  if (timer_reg == RST_LAST)    state_next = ST_SETTLE;
      ST_SETTLE:    if (timer_reg == SETTLE_LAST) state_next = ST_RDY;
      ST_RDY:       state_next = ST_RDY;
      default:      state_next = ST_OFF;
    endcase
    if (STOP) state_next = ST_OFF;
    if (state_next != state_reg) timer_next = '0;

    // Pins follow the current state one edge later, hence decode of state_reg.
    case (state_reg)
      ST_RST_HOLD: pwdn_next = 1'b0;
      ST_SETTLE: begin
        pwdn_next      = 1'b0;
        cam_rst_n_next = 1'b1;
      end
      ST_RDY: begin
        pwdn_next      = 1'b0;
        cam_rst_n_next = 1'b1;
        ready_next     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_OFF;
      timer_reg     <= '0;
      pwdn_reg      <= 1'b1;
      cam_rst_n_reg <= 1'b0;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      pwdn_reg      <= pwdn_next;
      cam_rst_n_reg <= cam_rst_n_next;
      busy_reg      <= busy_next;
      ready_reg     <= ready_next;
    end
  end

  assign div_apply_now = DIV_LOAD && ((state_reg == ST_OFF) || STOP);
  assign div_load_pend = DIV_LOAD && (state_reg == ST_RDY) && !STOP;

`ifdef XCLK_IDLE_GATE_EN
  assign div_clr = (state_reg == ST_OFF) || STOP;
`else
  assign div_clr = 1'b0;
`endif

  xclk_div_core #(
    .DIV_W    (DIV_W),
    .DEF_HALF (DEF_HALF)
  ) u_div (
    .clk       (CLK_IN),
    .rst_n     (RST_N),
    .clr       (div_clr),
    .load      (div_load_pend),
    .apply_now (div_apply_now),
    .half_in   (DIV_HALF_IN),
    .xclk      (CLK_XCLK)
  );

  assign CAM_PWDN  = pwdn_reg;
  assign CAM_RST_N = cam_rst_n_reg;
  assign BUSY      = busy_reg;
  assign READY     = ready_reg;

endmodule

// File: tb/tb_cam_xclk_seq.sv
// Bench for cam_xclk_seq: phase/duration model checked every cycle plus literal pins.
module tb_cam_xclk_seq;
  localparam int DIV_W = 6;
  localparam int DEF_HALF = 2;
  localparam int P = 4;
  localparam int R = 3;
  localparam int S = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, div_load = 1'b0;
  logic [DIV_W-1:0] div_half_in = '0;
  logic xclk, pwdn, cam_rst_n, busy, ready;

  int checks = 0, failures = 0, edge_n = 0;

  // model state: sequence age in edges, divider half-period for the current XCLK level run
  bit m_on, pend_v, run_valid;
  int m_age, cur_half, pend_half, run_len;
  logic prev_x;
  bit s_start, s_stop, s_load, in_off, in_rdy, imm, pnd, gated;
  int s_half;
  logic e_pwdn, e_rstn, e_busy, e_ready;
  int e0;

  cam_xclk_seq #(
    .DIV_W(DIV_W), .DEF_HALF(DEF_HALF), .PWDN_CYC(P), .RST_CYC(R), .SETTLE_CYC(S), .CNT_W(16)
  ) dut (
    .CLK_IN(clk), .RST_N(rst_n), .START(start), .STOP(stop), .DIV_LOAD(div_load),
    .DIV_HALF_IN(div_half_in), .CLK_XCLK(xclk), .CAM_PWDN(pwdn), .CAM_RST_N(cam_rst_n),
    .BUSY(busy), .READY(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 0; m_age = 0; cur_half = DEF_HALF; pend_v = 0;
      run_valid = 0; run_len = 0; prev_x = 1'b0;
    end else begin
      edge_n++;
      s_start = start; s_stop = stop; s_load = div_load;
      s_half = (div_half_in == 0) ? 1 : int'(div_half_in);
      in_off = !m_on;
      in_rdy = m_on && (m_age >= P + R + S);
      imm = s_load && (in_off || s_stop);
      pnd = s_load && in_rdy && !s_stop;
      gated = in_off || s_stop;

      if (!m_on)                  {e_pwdn, e_rstn, e_busy, e_ready} = 4'b1000;
      else if (m_age < P)         {e_pwdn, e_rstn, e_busy, e_ready} = 4'b1010;
      else if (m_age < P + R)     {e_pwdn, e_rstn, e_busy, e_ready} = 4'b0010;
      else if (m_age < P + R + S) {e_pwdn, e_rstn, e_busy, e_ready} = 4'b0110;
      else                        {e_pwdn, e_rstn, e_busy, e_ready} = 4'b0101;

      if (s_stop) m_on = 0;
      else if (s_start && !m_on) begin m_on = 1; m_age = 0; end
      else if (m_on && m_age < 1000) m_age++;

      #1;
      chk("pwdn", pwdn, e_pwdn);
      chk("cam_rst_n", cam_rst_n, e_rstn);
      chk("busy", busy, e_busy);
      chk("ready", ready, e_ready);

`ifdef XCLK_IDLE_GATE_EN
      if (gated) begin
        chk("xclk_gated", xclk, 0);
        if (imm) begin cur_half = s_half; pend_v = 0; end
        run_len = 1; run_valid = 1; prev_x = 1'b0;
      end else
`endif
      if (imm) begin
        chk("xclk_hold_on_load", xclk, prev_x);
        cur_half = s_half; pend_v = 0; run_len = 1; run_valid = 1;
      end else if (xclk !== prev_x) begin
        if (run_valid) chk("xclk_run", run_len, cur_half);
        if (prev_x === 1'b1 && pend_v) begin cur_half = pend_half; pend_v = 0; end
        run_len = 1; run_valid = 1; prev_x = xclk;
      end else begin
        run_len++;
        if (run_valid && run_len > cur_half) chk("xclk_run_long", run_len, cur_half);
      end
      if (pnd) begin pend_half = s_half; pend_v = 1; end
    end
  end

  task automatic go_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic pulse_at(input int e, input bit st, input bit sp, input bit ld, input int h);
    go_to(e - 1);
    start = st; stop = sp; div_load = ld; div_half_in = h[DIV_W-1:0];
    $display("edge %0d: start=%0b stop=%0b load=%0b half=%0d", e, st, sp, ld, h);
    go_to(e);
    start = 0; stop = 0; div_load = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_xclk"}, xclk, 0);
    chk({tag, "_pwdn"}, pwdn, 1);
    chk({tag, "_cam_rst_n"}, cam_rst_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, ready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d actual=timeout required=finish", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
`ifndef XCLK_IDLE_GATE_EN
    go_to(2); chk("xclk_e2", xclk, 1);
    go_to(4); chk("xclk_e4", xclk, 0);
`else
    go_to(4); chk("xclk_off_e4", xclk, 0);
`endif
    pulse_at(10, 1, 0, 0, 0);
    chk("busy_e10", busy, 0);
    go_to(11); chk("busy_e11", busy, 1);
    go_to(14); chk("pwdn_e14", pwdn, 1);
    go_to(15); chk("pwdn_e15", pwdn, 0);
    go_to(17); chk("rstn_e17", cam_rst_n, 0);
    go_to(18); chk("rstn_e18", cam_rst_n, 1);
    go_to(22); chk("ready_e22", ready, 0);
    go_to(23); chk("ready_e23", ready, 1); chk("busy_e23", busy, 0);

    pulse_at(25, 0, 0, 1, 5);
`ifndef XCLK_IDLE_GATE_EN
    go_to(27); chk("xclk_e27", xclk, 1);
    go_to(28); chk("xclk_e28", xclk, 0);
    go_to(32); chk("xclk_e32", xclk, 0);
    go_to(33); chk("xclk_e33", xclk, 1);
    go_to(38); chk("xclk_e38", xclk, 0);
`endif
    pulse_at(40, 0, 0, 1, 0);
`ifndef XCLK_IDLE_GATE_EN
    go_to(49); chk("xclk_e49", xclk, 1);
    go_to(50); chk("xclk_e50", xclk, 0);
`endif
    pulse_at(52, 0, 0, 1, 2);

    pulse_at(60, 0, 1, 0, 0);
    go_to(61); chk("ready_after_stop", ready, 0);
    pulse_at(65, 1, 0, 0, 0);
    pulse_at(71, 0, 1, 0, 0);
    chk("pwdn_rsthold_e71", pwdn, 0);
    go_to(72);
    chk("pwdn_stop_e72", pwdn, 1); chk("busy_stop_e72", busy, 0); chk("rstn_stop_e72", cam_rst_n, 0);
    pulse_at(80, 1, 0, 0, 0);
    go_to(81); chk("busy_e81", busy, 1);
    go_to(92); chk("ready_e92", ready, 0);
    go_to(93); chk("ready_e93", ready, 1);

    pulse_at(100, 0, 1, 0, 0);
    pulse_at(105, 0, 0, 1, 3);
    pulse_at(110, 1, 1, 0, 0);
    go_to(111); chk("busy_start_stop", busy, 0);
    go_to(115); chk("pwdn_start_stop", pwdn, 1);
    pulse_at(120, 1, 0, 0, 0);
    pulse_at(123, 0, 0, 1, 7);
    go_to(133); chk("ready_e133", ready, 1);
    pulse_at(136, 0, 1, 1, 2);
    go_to(138); chk("busy_e138", busy, 0);

    pulse_at(140, 1, 0, 0, 0);
    go_to(149);
    for (int i = 0; i < 8 && xclk !== 1'b1; i++) @(negedge clk);
    chk("xclk_high_in_settle", xclk, 1);
    chk("rstn_in_settle", cam_rst_n, 1);
    #2 rst_n = 1'b0;
    $display("async reset asserted after edge %0d", edge_n);
    #1 chk_reset_vals("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = edge_n;
`ifndef XCLK_IDLE_GATE_EN
    go_to(e0 + 2); chk("xclk_post_rst", xclk, 1);
`else
    go_to(e0 + 2); chk("xclk_post_rst", xclk, 0);
`endif
    go_to(e0 + 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
